// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings, state enum and default sizing for the elevator car controller
package elevator_pkg;

    localparam int DEFAULT_LEVELS        = 8;
    localparam int DEFAULT_LEVEL_W       = 3;
    localparam int DEFAULT_TRAVEL_CYCLES = 4;
    localparam int DEFAULT_DOOR_CYCLES   = 6;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN
    } state_e;

    function automatic dir_e reverse_dir(input dir_e d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// rtl/elevator_scheduler_if.sv - call vectors from the buttons block and the clear pulses returned to it
interface elevator_scheduler_if
    import elevator_pkg::*;
#(
    parameter int LEVELS = DEFAULT_LEVELS
);
    logic [LEVELS-1:0] active_in_levels;
    logic [LEVELS-1:0] active_out_up_levels;
    logic [LEVELS-1:0] active_out_down_levels;
    logic [LEVELS-1:0] inactivate_in_levels;
    logic [LEVELS-1:0] inactivate_out_up_levels;
    logic [LEVELS-1:0] inactivate_out_down_levels;

    modport master (
        output active_in_levels,
        output active_out_up_levels,
        output active_out_down_levels,
        input  inactivate_in_levels,
        input  inactivate_out_up_levels,
        input  inactivate_out_down_levels
    );

    modport slave (
        input  active_in_levels,
        input  active_out_up_levels,
        input  active_out_down_levels,
        output inactivate_in_levels,
        output inactivate_out_up_levels,
        output inactivate_out_down_levels
    );
endinterface

// File: rtl/level_request_scan.sv
// rtl/level_request_scan.sv - classifies pending requests as at, above or below a given floor
module level_request_scan
    import elevator_pkg::*;
#(
    parameter int LEVELS  = DEFAULT_LEVELS,
    parameter int LEVEL_W = DEFAULT_LEVEL_W
) (
    input  logic [LEVELS-1:0]  req,
    input  logic [LEVEL_W-1:0] level,
    output logic               req_here,
    output logic               req_above,
    output logic               req_below
);

    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            if (req[i]) begin
                if (i == int'(level)) begin
                    req_here = 1'b1;
                end else if (i > int'(level)) begin
                    req_above = 1'b1;
                end else begin
                    req_below = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - directional-sweep car controller: motion, door dwell and call clearing
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int LEVELS        = DEFAULT_LEVELS,
    parameter int LEVEL_W       = DEFAULT_LEVEL_W,
    parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    elevator_scheduler_if.slave calls,
    output logic [LEVEL_W-1:0]  current_level,
    output logic [1:0]          direction,
    output logic                moving,
    output logic                door_open
);

    localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0]  DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] TOP_LEVEL   = LEVEL_W'(LEVELS - 1);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    dir_e               last_dir_q, last_dir_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TCNT_W-1:0]  travel_q, travel_d;
    logic [DCNT_W-1:0]  door_q, door_d;
    logic [LEVELS-1:0]  clr_in_q, clr_in_d;
    logic [LEVELS-1:0]  clr_up_q, clr_up_d;
    logic [LEVELS-1:0]  clr_dn_q, clr_dn_d;

    logic [LEVELS-1:0]  in_m, up_m, dn_m, req;
    logic [LEVELS-1:0]  lvl_mask, next_mask, same_m, opp_m;
    logic [LEVEL_W-1:0] next_level;
    logic               here_c, above_c, below_c;
    logic               here_n, above_n, below_n;
    logic               going_up, stop_c, ahead_c, behind_c;
    logic               fresh_here, opp_here;
    dir_e               rev_dir;

    // Bits already being pulsed this cycle are hidden so a call is never cleared twice.
    assign in_m = calls.active_in_levels       & ~clr_in_q;
    assign up_m = calls.active_out_up_levels   & ~clr_up_q;
    assign dn_m = calls.active_out_down_levels & ~clr_dn_q;
    assign req  = in_m | up_m | dn_m;

    assign going_up = (dir_q == DIR_UP);

    always_comb begin
        next_level = level_q;
        if (going_up) begin
            if (level_q != TOP_LEVEL) next_level = level_q + 1'b1;
        end else begin
            if (level_q != '0) next_level = level_q - 1'b1;
        end
    end

    assign lvl_mask  = LEVELS'(1) << level_q;
    assign next_mask = LEVELS'(1) << next_level;

    level_request_scan #(.LEVELS(LEVELS), .LEVEL_W(LEVEL_W)) u_scan_here (
        .req       (req),
        .level     (level_q),
        .req_here  (here_c),
        .req_above (above_c),
        .req_below (below_c)
    );

    level_request_scan #(.LEVELS(LEVELS), .LEVEL_W(LEVEL_W)) u_scan_next (
        .req       (req),
        .level     (next_level),
        .req_here  (here_n),
        .req_above (above_n),
        .req_below (below_n)
    );

    // An opposite-direction hall call only stops the car when it is the last thing ahead.
    always_comb begin
        if (going_up) begin
            stop_c = (next_level == TOP_LEVEL) ||
                     (here_n && (|((in_m | up_m) & next_mask) ||
                                 (|(dn_m & next_mask) && !above_n)));
        end else begin
            stop_c = (next_level == '0) ||
                     (here_n && (|((in_m | dn_m) & next_mask) ||
                                 (|(up_m & next_mask) && !below_n)));
        end
    end

    assign ahead_c    = (last_dir_q == DIR_UP) ? above_c : below_c;
    assign behind_c   = (last_dir_q == DIR_UP) ? below_c : above_c;
    assign same_m     = (last_dir_q == DIR_UP) ? up_m : dn_m;
    assign opp_m      = (last_dir_q == DIR_UP) ? dn_m : up_m;
    assign fresh_here = |((in_m | same_m) & lvl_mask);
    assign opp_here   = |(opp_m & lvl_mask);
    assign rev_dir    = reverse_dir(last_dir_q);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        level_d    = level_q;
        travel_d   = travel_q;
        door_d     = door_q;
        clr_in_d   = '0;
        clr_up_d   = '0;
        clr_dn_d   = '0;

        case (state_q)
            IDLE: begin
                travel_d = '0;
                door_d   = '0;
                if (here_c) begin
                    state_d  = DOOR_OPEN;
                    dir_d    = DIR_IDLE;
                    clr_in_d = in_m & lvl_mask;
                    clr_up_d = up_m & lvl_mask;
                    clr_dn_d = dn_m & lvl_mask;
                end else if (above_c && below_c) begin
                    state_d = MOVING;
                    dir_d   = last_dir_q;
                end else if (above_c) begin
                    state_d    = MOVING;
                    dir_d      = DIR_UP;
                    last_dir_d = DIR_UP;
                end else if (below_c) begin
                    state_d    = MOVING;
                    dir_d      = DIR_DOWN;
                    last_dir_d = DIR_DOWN;
                end else begin
                    dir_d = DIR_IDLE;
                end
            end

            MOVING: begin
                if (travel_q != TRAVEL_LAST) begin
                    travel_d = travel_q + 1'b1;
                end else begin
                    travel_d = '0;
                    level_d  = next_level;
                    if (req == '0) begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end else if (stop_c) begin
                        state_d  = DOOR_OPEN;
                        door_d   = '0;
                        clr_in_d = in_m & next_mask;
                        if (going_up) begin
                            clr_up_d = up_m & next_mask;
                            clr_dn_d = above_n ? '0 : (dn_m & next_mask);
                        end else begin
                            clr_dn_d = dn_m & next_mask;
                            clr_up_d = below_n ? '0 : (up_m & next_mask);
                        end
                    end
                end
            end

            DOOR_OPEN: begin
                door_d = door_q + 1'b1;
                if (fresh_here) begin
                    // A late call at this floor is served by holding the door open longer.
                    door_d   = '0;
                    clr_in_d = in_m & lvl_mask;
                    if (last_dir_q == DIR_UP) clr_up_d = up_m & lvl_mask;
                    else                      clr_dn_d = dn_m & lvl_mask;
                end else if (door_q == DOOR_LAST) begin
                    door_d = '0;
                    if (ahead_c) begin
                        state_d = MOVING;
                        dir_d   = last_dir_q;
                    end else if (behind_c) begin
                        state_d    = MOVING;
                        dir_d      = rev_dir;
                        last_dir_d = rev_dir;
                    end else if (opp_here) begin
                        dir_d      = rev_dir;
                        last_dir_d = rev_dir;
                        if (last_dir_q == DIR_UP) clr_dn_d = dn_m & lvl_mask;
                        else                      clr_up_d = up_m & lvl_mask;
                    end else begin
                        state_d = IDLE;
                        dir_d   = DIR_IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                dir_d   = DIR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_IDLE;
            last_dir_q <= DIR_UP;
            level_q    <= '0;
            travel_q   <= '0;
            door_q     <= '0;
            clr_in_q   <= '0;
            clr_up_q   <= '0;
            clr_dn_q   <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            level_q    <= level_d;
            travel_q   <= travel_d;
            door_q     <= door_d;
            clr_in_q   <= clr_in_d;
            clr_up_q   <= clr_up_d;
            clr_dn_q   <= clr_dn_d;
        end
    end

    assign current_level                    = level_q;
    assign direction                        = dir_q;
    assign moving                           = (state_q == MOVING);
    assign door_open                        = (state_q == DOOR_OPEN);
    assign calls.inactivate_in_levels       = clr_in_q;
    assign calls.inactivate_out_up_levels   = clr_up_q;
    assign calls.inactivate_out_down_levels = clr_dn_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - directed self-checking bench for elevator_scheduler
module tb_elevator_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] current_level;
    logic [1:0] direction;
    logic       moving;
    logic       door_open;

    int checks;
    int passes;

    typedef struct {
        int         k;
        logic [2:0] lvl;
        logic       door;
        logic       mov;
        logic [1:0] dir;
        logic [7:0] ci;
        logic [7:0] cu;
        logic [7:0] cd;
    } exp_t;

    elevator_scheduler_if #(.LEVELS(8)) bus ();

    elevator_scheduler #(
        .LEVELS        (8),
        .LEVEL_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .calls         (bus.slave),
        .current_level (current_level),
        .direction     (direction),
        .moving        (moving),
        .door_open     (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, sample 2ns after the edge, then mimic the buttons block dropping served calls.
    task automatic step();
        @(posedge clk);
        #2;
        bus.active_in_levels       = bus.active_in_levels       & ~bus.inactivate_in_levels;
        bus.active_out_up_levels   = bus.active_out_up_levels   & ~bus.inactivate_out_up_levels;
        bus.active_out_down_levels = bus.active_out_down_levels & ~bus.inactivate_out_down_levels;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.active_in_levels       = '0;
        bus.active_out_up_levels   = '0;
        bus.active_out_down_levels = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        reset = 1'b0;
        bus.active_in_levels       = '0;
        bus.active_out_up_levels   = '0;
        bus.active_out_down_levels = '0;
        #1;
        obs = {current_level, door_open, moving, direction, bus.inactivate_in_levels,
               bus.inactivate_out_up_levels, bus.inactivate_out_down_levels};
        checks++;
        if (obs !== 31'h0) $display("FAIL reset_values actual=%h required=0", obs);
        else passes++;
        #22 reset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            obs = {current_level, door_open, moving, direction, bus.inactivate_in_levels,
                   bus.inactivate_out_up_levels, bus.inactivate_out_down_levels};
            checks++;
            if (obs !== 31'h0) $display("FAIL idle_no_calls cycle=%0d actual=%h required=0", k, obs);
            else passes++;
        end
    endtask

    task automatic test_call_here();
        int door_cycles;
        do_reset();
        bus.active_in_levels[0] = 1'b1;
        door_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (door_open === 1'b1) door_cycles++;
            if (k == 0) begin
                checks++;
                if ({door_open, bus.inactivate_in_levels} !== {1'b1, 8'h01})
                    $display("FAIL here_open door=%b clr=%h required door=1 clr=01", door_open, bus.inactivate_in_levels);
                else passes++;
            end
            if (k == 1) begin
                checks++;
                if (bus.inactivate_in_levels !== 8'h00)
                    $display("FAIL here_pulse_width clr=%h required=00", bus.inactivate_in_levels);
                else passes++;
            end
            if (k == 6) begin
                checks++;
                if ({door_open, moving, direction} !== 4'b0000)
                    $display("FAIL here_back_idle door=%b moving=%b dir=%b required 0 0 00", door_open, moving, direction);
                else passes++;
            end
        end
        checks++;
        if (door_cycles !== 6) $display("FAIL here_dwell_len actual=%0d required=6", door_cycles);
        else passes++;
    endtask

    task automatic test_travel_up();
        logic [2:0] exp_lvl;
        do_reset();
        bus.active_in_levels[3] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            exp_lvl = 3'(k / 4);
            checks++;
            if (current_level !== exp_lvl)
                $display("FAIL travel_level k=%0d actual=%0d required=%0d", k, current_level, exp_lvl);
            else passes++;
            if (k < 12) begin
                checks++;
                if ({door_open, moving, direction} !== 4'b0101)
                    $display("FAIL travel_moving k=%0d door=%b moving=%b dir=%b required 0 1 01", k, door_open, moving, direction);
                else passes++;
            end else begin
                checks++;
                if ({door_open, moving, bus.inactivate_in_levels} !== {1'b1, 1'b0, 8'h08})
                    $display("FAIL travel_stop door=%b moving=%b clr=%h required 1 0 08", door_open, moving, bus.inactivate_in_levels);
                else passes++;
            end
        end
    endtask

    task automatic test_sweep();
        exp_t tbl[9];
        logic [30:0] obs;
        logic [30:0] req;
        tbl[0] = '{0,  3'd0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{4,  3'd1, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8,  3'd2, 1'b1, 1'b0, 2'b01, 8'h00, 8'h04, 8'h00};
        tbl[3] = '{13, 3'd2, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{14, 3'd2, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{26, 3'd5, 1'b1, 1'b0, 2'b01, 8'h20, 8'h00, 8'h00};
        tbl[6] = '{32, 3'd5, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h00};
        tbl[7] = '{44, 3'd2, 1'b1, 1'b0, 2'b10, 8'h00, 8'h00, 8'h04};
        tbl[8] = '{50, 3'd2, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00};
        do_reset();
        bus.active_out_up_levels[2]   = 1'b1;
        bus.active_out_down_levels[2] = 1'b1;
        bus.active_in_levels[5]       = 1'b1;
        for (int k = 0; k <= 52; k++) begin
            step();
            for (int t = 0; t < 9; t++) begin
                if (tbl[t].k == k) begin
                    obs = {current_level, door_open, moving, direction, bus.inactivate_in_levels,
                           bus.inactivate_out_up_levels, bus.inactivate_out_down_levels};
                    req = {tbl[t].lvl, tbl[t].door, tbl[t].mov, tbl[t].dir, tbl[t].ci, tbl[t].cu, tbl[t].cd};
                    checks++;
                    if (obs !== req) $display("FAIL sweep k=%0d actual=%h required=%h", k, obs, req);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_dwell_restart();
        do_reset();
        bus.active_in_levels[4] = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            step();
            if (k == 16) begin
                checks++;
                if ({current_level, door_open, bus.inactivate_in_levels} !== {3'd4, 1'b1, 8'h10})
                    $display("FAIL dwell_arrive lvl=%0d door=%b clr=%h required 4 1 10", current_level, door_open, bus.inactivate_in_levels);
                else passes++;
            end
            if (k == 18) bus.active_in_levels[4] = 1'b1;
            if (k == 19 || k == 20) begin
                checks++;
                if ({door_open, bus.inactivate_in_levels} !== {1'b1, (k == 19) ? 8'h10 : 8'h00})
                    $display("FAIL dwell_repulse k=%0d door=%b clr=%h", k, door_open, bus.inactivate_in_levels);
                else passes++;
            end
            if (k == 24) begin
                checks++;
                if (door_open !== 1'b1) $display("FAIL dwell_extended door=%b required=1", door_open);
                else passes++;
            end
            if (k == 25) begin
                checks++;
                if ({door_open, moving, direction} !== 4'b0000)
                    $display("FAIL dwell_close door=%b moving=%b dir=%b required 0 0 00", door_open, moving, direction);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_midmove();
        do_reset();
        bus.active_in_levels[5] = 1'b1;
        for (int k = 0; k <= 10; k++) step();
        checks++;
        if ({current_level, moving} !== {3'd2, 1'b1})
            $display("FAIL midmove_pre lvl=%0d moving=%b required 2 1", current_level, moving);
        else passes++;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({current_level, door_open, moving, direction} !== 7'h0)
            $display("FAIL midmove_async lvl=%0d door=%b moving=%b dir=%b required all 0", current_level, door_open, moving, direction);
        else passes++;
        bus.active_in_levels = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({current_level, door_open, moving, direction} !== 7'h0)
            $display("FAIL midmove_after lvl=%0d door=%b moving=%b dir=%b required all 0", current_level, door_open, moving, direction);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b0;
        bus.active_in_levels       = '0;
        bus.active_out_up_levels   = '0;
        bus.active_out_down_levels = '0;
        test_reset();
        test_call_here();
        test_travel_up();
        test_sweep();
        test_dwell_restart();
        test_reset_midmove();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
